// File: rtl/hazard_pipe_ctrl_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared constants for the hazard / control-pipeline block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 5;

  // Holds the remaining flush count, up to FLUSH_CYCLES-1 = 3.
  localparam int unsigned FLUSH_CNT_W = 2;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef struct packed {
    logic regWrite;
    logic memRead;
  } ctrlBits_t;

  localparam ctrlBits_t CTRL_BUBBLE = '{regWrite: 1'b0, memRead: 1'b0};

endpackage

`default_nettype wire

// File: rtl/hazard_pipe_ctrl_stage_reg.sv
// ============================================================================
// Module      : ctrl_stage_reg
// Description : One pipeline stage register with hold and bubble controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_stage_reg
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_hold,
  input  logic                  i_bubble,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_regWrite,
  input  logic                  i_memRead,
  output logic [REG_ADDR_W-1:0] o_rs1,
  output logic [REG_ADDR_W-1:0] o_rs2,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  o_regWrite,
  output logic                  o_memRead
);

  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  ctrlBits_t             r_ctrl;

  // Hold wins over bubble: a frozen stage keeps its contents untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
      r_ctrl <= CTRL_BUBBLE;
    end else if (!i_hold) begin
      if (i_bubble) begin
        r_rs1  <= '0;
        r_rs2  <= '0;
        r_rd   <= '0;
        r_ctrl <= CTRL_BUBBLE;
      end else begin
        r_rs1  <= i_rs1;
        r_rs2  <= i_rs2;
        r_rd   <= i_rd;
        r_ctrl <= '{regWrite: i_regWrite, memRead: i_memRead};
      end
    end
  end

  assign o_rs1      = r_rs1;
  assign o_rs2      = r_rs2;
  assign o_rd       = r_rd;
  assign o_regWrite = r_ctrl.regWrite;
  assign o_memRead  = r_ctrl.memRead;

endmodule

`default_nettype wire

// File: rtl/hazard_pipe_ctrl.sv
// ============================================================================
// Module      : hazard_pipe_ctrl
// Description : Load-use / branch-flush / memory-freeze hazard control with
//               ID/EX, EX/MEM and MEM/WB control-field pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_pipe_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_ADDR_W-1:0]  IF_ID_RegisterRs1,
  input  logic [REG_ADDR_W-1:0]  IF_ID_RegisterRs2,
  input  logic [REG_ADDR_W-1:0]  IF_ID_RegisterRd,
  input  logic                   IF_ID_UsesRs1,
  input  logic                   IF_ID_UsesRs2,
  input  logic                   IF_ID_RegWrite,
  input  logic                   IF_ID_MemRead,
  input  logic                   branch_taken,
  input  logic                   mem_busy,
  output logic [REG_ADDR_W-1:0]  ID_EX_RegisterRs1,
  output logic [REG_ADDR_W-1:0]  ID_EX_RegisterRs2,
  output logic [REG_ADDR_W-1:0]  ID_EX_RegisterRd,
  output logic                   ID_EX_RegWrite,
  output logic                   ID_EX_MemRead,
  output logic [REG_ADDR_W-1:0]  EX_MEM_RegisterRd,
  output logic                   EX_MEM_RegWrite,
  output logic [REG_ADDR_W-1:0]  MEM_WB_RegisterRd,
  output logic                   MEM_WB_RegWrite,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [FLUSH_CNT_W-1:0] C_FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  logic [0:0]             r_state;
  logic [0:0]             w_nextState;
  logic [FLUSH_CNT_W-1:0] r_cnt;
  logic [FLUSH_CNT_W-1:0] w_nextCnt;
  logic [STALL_CNT_W-1:0] r_stallCnt;

  logic w_loadUse;
  logic w_hold;
  logic w_bubble;
  logic w_stallInc;

  logic [REG_ADDR_W-1:0] w_unusedExRs1;
  logic [REG_ADDR_W-1:0] w_unusedExRs2;
  logic                  w_unusedExMemRead;
  logic [REG_ADDR_W-1:0] w_unusedWbRs1;
  logic [REG_ADDR_W-1:0] w_unusedWbRs2;
  logic                  w_unusedWbMemRead;

  assign w_loadUse = ID_EX_MemRead && (ID_EX_RegisterRd != '0) &&
                     ((IF_ID_UsesRs1 && (ID_EX_RegisterRd == IF_ID_RegisterRs1)) ||
                      (IF_ID_UsesRs2 && (ID_EX_RegisterRd == IF_ID_RegisterRs2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // A branch during FLUSH reloads the count, restarting the bubble train.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    if (!mem_busy) begin
      if (branch_taken) begin
        if (FLUSH_CYCLES > 1) begin
          w_nextState = ST_FLUSH;
          w_nextCnt   = C_FLUSH_LOAD;
        end else begin
          w_nextState = ST_RUN;
          w_nextCnt   = '0;
        end
      end else if (r_state == ST_FLUSH) begin
        if (r_cnt <= FLUSH_CNT_W'(1)) begin
          w_nextState = ST_RUN;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt - 1'b1;
        end
      end
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    w_hold      = 1'b1;
    w_bubble    = 1'b0;
    w_stallInc  = 1'b0;
    if (rst_n && !mem_busy) begin
      w_hold = 1'b0;
      if (branch_taken || (r_state == ST_FLUSH)) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        w_bubble    = 1'b1;
      end else if (w_loadUse) begin
        w_bubble   = 1'b1;
        w_stallInc = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (w_stallInc && (r_stallCnt != {STALL_CNT_W{1'b1}})) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  assign stall_count = r_stallCnt;

  ctrl_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_idEx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hold     (w_hold),
    .i_bubble   (w_bubble),
    .i_rs1      (IF_ID_RegisterRs1),
    .i_rs2      (IF_ID_RegisterRs2),
    .i_rd       (IF_ID_RegisterRd),
    .i_regWrite (IF_ID_RegWrite),
    .i_memRead  (IF_ID_MemRead),
    .o_rs1      (ID_EX_RegisterRs1),
    .o_rs2      (ID_EX_RegisterRs2),
    .o_rd       (ID_EX_RegisterRd),
    .o_regWrite (ID_EX_RegWrite),
    .o_memRead  (ID_EX_MemRead)
  );

  // Later stages only need Rd/RegWrite; bubbles drain through them unchanged.
  ctrl_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_exMem (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hold     (w_hold),
    .i_bubble   (1'b0),
    .i_rs1      ('0),
    .i_rs2      ('0),
    .i_rd       (ID_EX_RegisterRd),
    .i_regWrite (ID_EX_RegWrite),
    .i_memRead  (1'b0),
    .o_rs1      (w_unusedExRs1),
    .o_rs2      (w_unusedExRs2),
    .o_rd       (EX_MEM_RegisterRd),
    .o_regWrite (EX_MEM_RegWrite),
    .o_memRead  (w_unusedExMemRead)
  );

  ctrl_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_memWb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hold     (w_hold),
    .i_bubble   (1'b0),
    .i_rs1      ('0),
    .i_rs2      ('0),
    .i_rd       (EX_MEM_RegisterRd),
    .i_regWrite (EX_MEM_RegWrite),
    .i_memRead  (1'b0),
    .o_rs1      (w_unusedWbRs1),
    .o_rs2      (w_unusedWbRs2),
    .o_rd       (MEM_WB_RegisterRd),
    .o_regWrite (MEM_WB_RegWrite),
    .o_memRead  (w_unusedWbMemRead)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_pipe_ctrl.sv
// ============================================================================
// Module      : tb_hazard_pipe_ctrl
// Description : Scoreboard bench for hazard_pipe_ctrl (FLUSH_CYCLES=2,
//               STALL_CNT_W=2) with directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_pipe_ctrl;

  localparam int RW  = 5;
  localparam int FC  = 2;
  localparam int SCW = 2;
  localparam int SAT = (1 << SCW) - 1;

  typedef struct packed {
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
  } fld_t;

  typedef struct packed {
    fld_t           idex;
    logic [RW-1:0]  exRd;
    logic           exRw;
    logic [RW-1:0]  wbRd;
    logic           wbRw;
    logic           pcw;
    logic           ifw;
    logic           fl;
    logic [SCW-1:0] sc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [RW-1:0]  inRs1 = '0, inRs2 = '0, inRd = '0;
  logic           inUses1 = 1'b0, inUses2 = 1'b0, inRegWrite = 1'b0, inMemRead = 1'b0;
  logic           branchTaken = 1'b0, memBusy = 1'b0;
  logic [RW-1:0]  idExRs1, idExRs2, idExRd, exMemRd, memWbRd;
  logic           idExRw, idExMr, exMemRw, memWbRw;
  logic           pcWrite, ifIdWrite, ifIdFlush;
  logic [SCW-1:0] stallCount;

  hazard_pipe_ctrl #(.REG_ADDR_W(RW), .FLUSH_CYCLES(FC), .STALL_CNT_W(SCW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .IF_ID_RegisterRs1 (inRs1),
    .IF_ID_RegisterRs2 (inRs2),
    .IF_ID_RegisterRd  (inRd),
    .IF_ID_UsesRs1     (inUses1),
    .IF_ID_UsesRs2     (inUses2),
    .IF_ID_RegWrite    (inRegWrite),
    .IF_ID_MemRead     (inMemRead),
    .branch_taken      (branchTaken),
    .mem_busy          (memBusy),
    .ID_EX_RegisterRs1 (idExRs1),
    .ID_EX_RegisterRs2 (idExRs2),
    .ID_EX_RegisterRd  (idExRd),
    .ID_EX_RegWrite    (idExRw),
    .ID_EX_MemRead     (idExMr),
    .EX_MEM_RegisterRd (exMemRd),
    .EX_MEM_RegWrite   (exMemRw),
    .MEM_WB_RegisterRd (memWbRd),
    .MEM_WB_RegWrite   (memWbRw),
    .pc_write          (pcWrite),
    .if_id_write       (ifIdWrite),
    .if_id_flush       (ifIdFlush),
    .stall_count       (stallCount)
  );

  always #5 clk = ~clk;

  // Reference model: three in-flight instruction slots, remaining flush
  // bubbles and a saturating count of load-use stalls.
  fld_t mIdEx = '0, mExMem = '0, mMemWb = '0;
  int   mFlushLeft = 0;
  int   mStalls = 0;
  exp_t expQ[$];
  int   nChecks = 0;
  int   nErrors = 0;

  task automatic step(input logic rstN, input fld_t f, input logic u1, input logic u2,
                      input logic br, input logic busy);
    exp_t e;
    fld_t nxt;
    logic lu;
    @(posedge clk);
    #1;
    rst_n = rstN;
    inRs1 = f.rs1; inRs2 = f.rs2; inRd = f.rd;
    inRegWrite = f.rw; inMemRead = f.mr;
    inUses1 = u1; inUses2 = u2;
    branchTaken = br; memBusy = busy;
    if (!rstN) begin
      mIdEx = '0; mExMem = '0; mMemWb = '0;
      mFlushLeft = 0; mStalls = 0;
    end
    e = '0;
    e.idex = mIdEx;
    e.exRd = mExMem.rd; e.exRw = mExMem.rw;
    e.wbRd = mMemWb.rd; e.wbRw = mMemWb.rw;
    e.sc   = SCW'(mStalls);
    if (rstN && !busy) begin
      lu  = mIdEx.mr && (mIdEx.rd != 0) &&
            ((u1 && mIdEx.rd == f.rs1) || (u2 && mIdEx.rd == f.rs2));
      nxt = '0;
      if (br) begin
        e.fl = 1'b1; e.pcw = 1'b1; e.ifw = 1'b1;
        mFlushLeft = FC - 1;
      end else if (mFlushLeft > 0) begin
        e.fl = 1'b1; e.pcw = 1'b1; e.ifw = 1'b1;
        mFlushLeft--;
      end else if (lu) begin
        mStalls = (mStalls < SAT) ? mStalls + 1 : SAT;
      end else begin
        e.pcw = 1'b1; e.ifw = 1'b1;
        nxt = f;
      end
      mMemWb = mExMem;
      mExMem = mIdEx;
      mIdEx  = nxt;
    end
    expQ.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    nChecks++;
    if (act !== expv) begin
      nErrors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  exp_t monE;
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      chk("id_ex_rs1",   int'(idExRs1),    int'(monE.idex.rs1));
      chk("id_ex_rs2",   int'(idExRs2),    int'(monE.idex.rs2));
      chk("id_ex_rd",    int'(idExRd),     int'(monE.idex.rd));
      chk("id_ex_rw",    int'(idExRw),     int'(monE.idex.rw));
      chk("id_ex_mr",    int'(idExMr),     int'(monE.idex.mr));
      chk("ex_mem_rd",   int'(exMemRd),    int'(monE.exRd));
      chk("ex_mem_rw",   int'(exMemRw),    int'(monE.exRw));
      chk("mem_wb_rd",   int'(memWbRd),    int'(monE.wbRd));
      chk("mem_wb_rw",   int'(memWbRw),    int'(monE.wbRw));
      chk("pc_write",    int'(pcWrite),    int'(monE.pcw));
      chk("if_id_write", int'(ifIdWrite),  int'(monE.ifw));
      chk("if_id_flush", int'(ifIdFlush),  int'(monE.fl));
      chk("stall_count", int'(stallCount), int'(monE.sc));
    end
  end

  function automatic fld_t mk(input int r1, input int r2, input int d, input logic w, input logic m);
    fld_t f;
    f.rs1 = RW'(r1); f.rs2 = RW'(r2); f.rd = RW'(d); f.rw = w; f.mr = m;
    return f;
  endfunction

  initial begin
    fld_t nop, lw5, add65, addX0X7, lwX0, addRs2;
    fld_t rf;
    nop     = '0;
    lw5     = mk(1, 0, 5, 1'b1, 1'b1);
    add65   = mk(5, 1, 6, 1'b1, 1'b0);
    addX0X7 = mk(0, 7, 6, 1'b1, 1'b0);
    lwX0    = mk(2, 0, 0, 1'b1, 1'b1);
    addRs2  = mk(1, 5, 8, 1'b1, 1'b0);

    // Reset held, then first cycle after release
    step(1'b0, nop, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, nop, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use: one stall, then the add enters ID/EX
    step(1'b1, lw5,   1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, add65, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, add65, 1'b1, 1'b1, 1'b0, 1'b0);

    // No-hazard cases
    step(1'b1, lw5,     1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, addX0X7, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, lwX0,    1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(0, 0, 3, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, lw5,     1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, addRs2,  1'b1, 1'b0, 1'b0, 1'b0);

    // Branch flush and bubble drain
    step(1'b1, add65, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b1, nop, 1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous busy + branch + load-use, then release
    step(1'b1, lw5,   1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, add65, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, add65, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, add65, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, nop, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stall
    step(1'b1, lw5,   1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, add65, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, nop,   1'b0, 1'b0, 1'b0, 1'b0);

    // Counter saturation after 5 load-use events
    repeat (5) begin
      step(1'b1, lw5,   1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, add65, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, add65, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Random traffic biased towards hazards
    for (int i = 0; i < 500; i++) begin
      rf.rs1 = RW'($urandom_range(0, 7));
      rf.rs2 = RW'($urandom_range(0, 7));
      rf.rd  = RW'($urandom_range(0, 7));
      rf.mr  = ($urandom_range(0, 9) < 4);
      rf.rw  = rf.mr | 1'($urandom_range(0, 1));
      step(($urandom_range(0, 99) != 0), rf,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 15));
    end

    @(negedge clk);
    #1;
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
